// File: rtl/instr_prefetch_unit_if.sv
// Bundle of the fetch-side memory port, the redirect input and the decode handshake
// for instr_prefetch_unit; master is the prefetch unit, slave is its environment.
interface instr_prefetch_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rdy;
    logic            mem_valid;
    logic [XLEN-1:0] mem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;

    modport master (
        output mem_req, mem_we, mem_addr,
        input  mem_rdy, mem_valid, mem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr,
        output mem_rdy, mem_valid, mem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front-end: credit-limited in-order fetch, instruction queue, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_dropped counters.
module instr_prefetch_unit #(
    parameter int                XLEN            = 32,
    parameter logic [XLEN-1:0]   RESET_PC        = '0,
    parameter int                IBUF_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_prefetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]      perf_fetched,
    output logic [XLEN-1:0]      perf_dropped
`endif
);
    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(IBUF_DEPTH);
    localparam logic [OUT_W-1:0] MAXO_C  = OUT_W'(MAX_OUTSTANDING);

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  ent_instr_q [IBUF_DEPTH];
    logic [XLEN-1:0]  ent_instr_d [IBUF_DEPTH];
    logic [XLEN-1:0]  ent_pc_q    [IBUF_DEPTH];
    logic [XLEN-1:0]  ent_pc_d    [IBUF_DEPTH];

    logic             credit;
    logic             issue;
    logic             rsp_accept;
    logic             push;
    logic             pop;
    logic             drop_evt;
    logic [CNT_W:0]   occupancy;
    logic [XLEN-1:0]  rsp_pc;
    logic [IBUF_DEPTH-1:0] wr_en;

    assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(outstanding_q);
    assign credit     = (occupancy < DEPTH_C) && (outstanding_q < MAXO_C);
    assign bus.mem_req  = (state_q == ST_FETCH) && credit && !bus.redirect;
    assign bus.mem_we   = 1'b0;
    assign bus.mem_addr = fetch_pc_q;
    assign issue      = bus.mem_req && bus.mem_rdy;
    assign rsp_accept = bus.mem_valid && (outstanding_q != '0);
    assign push       = rsp_accept && (drop_cnt_q == '0) && !bus.redirect;
    assign pop        = bus.id_valid && bus.id_ready && !bus.redirect;
    assign drop_evt   = rsp_accept && ((drop_cnt_q != '0) || bus.redirect);

    // Outside a flush every in-flight read is live and sequential, so the oldest one
    // belongs to fetch_pc minus four bytes per outstanding request.
    assign rsp_pc = fetch_pc_q - (XLEN'(outstanding_q) << 2);

    assign bus.id_valid = (count_q != '0);
    assign bus.id_instr = ent_instr_q[rd_ptr_q];
    assign bus.id_pc    = ent_pc_q[rd_ptr_q];

    for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end

    always_comb begin
        for (int i = 0; i < IBUF_DEPTH; i++) begin
            ent_instr_d[i] = wr_en[i] ? bus.mem_rdata : ent_instr_q[i];
            ent_pc_d[i]    = wr_en[i] ? rsp_pc        : ent_pc_q[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (bus.redirect) begin
            // A response arriving in the redirect cycle is already accounted for here.
            fetch_pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
            outstanding_d = outstanding_q - OUT_W'(rsp_accept);
            drop_cnt_d    = outstanding_q - OUT_W'(rsp_accept);
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            state_d       = (drop_cnt_d != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(rsp_accept);
            if (rsp_accept && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - OUT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FLUSH: state_d = (drop_cnt_d == '0) ? ST_FETCH : ST_FLUSH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ent_instr_q[i] <= '0;
                ent_pc_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ent_instr_q[i] <= ent_instr_d[i];
                ent_pc_q[i]    <= ent_pc_d[i];
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
    logic [XLEN-1:0] perf_dropped_q, perf_dropped_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_dropped_d = perf_dropped_q;
        if (pop && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + XLEN'(1);
        end
        if (drop_evt && (perf_dropped_q != '1)) begin
            perf_dropped_d = perf_dropped_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomized bench for instr_prefetch_unit: a queue-level model of requests in flight and
// the instruction queue predicts every decode-side and memory-side output each cycle.
module tb_instr_prefetch_unit;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_prefetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    instr_prefetch_unit #(
        .XLEN(XLEN), .RESET_PC(RPC), .IBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    req_t        req_q[$];
    logic [31:0] ibuf_q[$];
    mreq_t       mem_q[$];
    logic [31:0] exp_pc;
    bit          idle;
    int          cyc;
    int unsigned n_pop;
    int unsigned n_drop;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Entered and left at a falling edge; asynchronous reset checked while asserted.
    task automatic do_reset(input int hold);
        rst = 1'b0;
        bus.mem_rdy = 1'b0; bus.mem_valid = 1'b0; bus.mem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_instr", bus.id_instr, 32'd0);
        check("rst_id_pc", bus.id_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        for (int i = 0; i < hold; i++) @(negedge clk);
        req_q.delete(); ibuf_q.delete(); mem_q.delete();
        exp_pc = RPC; idle = 1'b1; n_pop = 0; n_drop = 0;
        rst = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, wait for the next falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input int rdy_pct,
                        input int ready_pct, input int lat_min, input int lat_max);
        bit          exp_req;
        bit          stale_any;
        bit          rsp;
        bit          pushed;
        logic [31:0] push_pc;
        req_t        r;
        int          lat;

        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.mem_rdy     = ($urandom_range(99) < rdy_pct);
        bus.id_ready    = ($urandom_range(99) < ready_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = memf(mem_q[0].addr);
        end else if (mem_q.size() == 0 && $urandom_range(15) == 0) begin
            bus.mem_valid = 1'b1;            // unsolicited beat, must be ignored
            bus.mem_rdata = $urandom;
        end else begin
            bus.mem_valid = 1'b0;
            bus.mem_rdata = $urandom;
        end
        #1;

        check("id_valid", 32'(bus.id_valid), 32'(ibuf_q.size() > 0));
        if (ibuf_q.size() > 0) begin
            check("id_pc", bus.id_pc, ibuf_q[0]);
            check("id_instr", bus.id_instr, memf(ibuf_q[0]));
        end
        stale_any = 1'b0;
        foreach (req_q[i]) if (req_q[i].stale) stale_any = 1'b1;
        exp_req = !idle && !stale_any && !redir &&
                  (ibuf_q.size() + req_q.size() < DEPTH) && (req_q.size() < MAXO);
        check("mem_req", 32'(bus.mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", bus.mem_addr, exp_pc);
        check("mem_we", 32'(bus.mem_we), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, n_pop);
        check("perf_dropped", perf_dropped, n_drop);
`endif

        rsp    = bus.mem_valid && (req_q.size() > 0);
        pushed = 1'b0;
        push_pc = '0;
        if (rsp) begin
            r = req_q.pop_front();
            void'(mem_q.pop_front());
            if (!r.stale && !redir) begin
                pushed  = 1'b1;
                push_pc = r.pc;
            end else begin
                n_drop++;
            end
        end
        if (ibuf_q.size() > 0 && bus.id_ready && !redir) begin
            $display("pop  pc=%h instr=%h", ibuf_q[0], memf(ibuf_q[0]));
            void'(ibuf_q.pop_front());
            n_pop++;
        end
        if (pushed) ibuf_q.push_back(push_pc);
        if (redir) begin
            ibuf_q.delete();
            foreach (req_q[i]) req_q[i].stale = 1'b1;
            exp_pc = rpc & ~32'd3;
            $display("redirect to %h, %0d in flight dropped", exp_pc, req_q.size());
        end else if (exp_req && bus.mem_rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            req_q.push_back('{pc: exp_pc, stale: 1'b0});
            mem_q.push_back('{addr: exp_pc, due: cyc + lat});
            exp_pc = exp_pc + 32'd4;
        end
        idle = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int mode;
        cyc = 0;
        @(negedge clk);
        do_reset(2);

        // Stream from reset with single-cycle memory.
        for (int i = 0; i < 20; i++) step(1'b0, '0, 100, 100, 1, 1);
        // Backpressure: queue fills and issue stops, then one pop frees one slot.
        for (int i = 0; i < 12; i++) step(1'b0, '0, 100, 0, 1, 1);
        step(1'b0, '0, 100, 100, 1, 1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 100, 0, 1, 1);
        // Redirect to 0x103 with slow memory and reads in flight.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 100, 100, 3, 3);
        step(1'b1, 32'h0000_0103, 100, 100, 3, 3);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 100, 100, 3, 3);
        // Wrap through the top of the address space.
        step(1'b1, 32'hFFFF_FFF9, 100, 100, 1, 1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 100, 100, 1, 1);

        for (int seg = 0; seg < 16; seg++) begin
            mode = int'($urandom_range(3));
            if (seg == 8) do_reset(1);
            for (int i = 0; i < 150; i++) begin
                case (mode)
                    0: step(($urandom_range(40) == 0), $urandom, 100, 100, 1, 1);
                    1: step(($urandom_range(12) == 0), $urandom, 70, 60, 1, 4);
                    2: step(($urandom_range(30) == 0), $urandom, 90, 15, 1, 3);
                    default: step(($urandom_range(4) == 0), $urandom, 80, 80, 1, 3);
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
